// File: rtl/pu_feeder.sv
// Streaming front-end that pairs incoming pixels into dual-port window writes and
// sequences load/start/wait rounds for an img2col PU. Optional FEEDER_STALL_CNT_EN adds stall_cnt.
module pu_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int KSIZE      = 5,
   parameter int ADDR_W     = 5,
   parameter int ROUND_W    = 6,
   parameter int ROUNDS     = 32
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] new1,
   output logic [DATA_WIDTH-1:0] new2,
   output logic [ADDR_W-1:0]     adrs_in1,
   output logic [ADDR_W-1:0]     adrs_in2,
   output logic                  wr1,
   output logic                  wr2,
   output logic                  start,
   output logic [ROUND_W-1:0]    round,
   input  logic                  pu_done,
   output logic                  frame_done
`ifdef FEEDER_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int                 WIN        = KSIZE * KSIZE;
   localparam logic [ADDR_W-1:0]  N_FULL     = ADDR_W'(WIN);
   localparam logic [ADDR_W-1:0]  N_COL      = ADDR_W'(KSIZE);
   localparam logic [ADDR_W-1:0]  BASE_COL   = ADDR_W'(WIN - KSIZE);
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, START, WAIT} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_W-1:0]     k;
   logic [ADDR_W-1:0]     base;
   logic [ADDR_W-1:0]     k_last;
   logic [ADDR_W-1:0]     adrs_cur;
   logic [ADDR_W-1:0]     adrs_prev;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_full;
   logic                  accept;
   logic                  last_pix;
   logic                  start_nxt;
   logic                  round_done;
   logic                  frame_end;

   // Round 0 loads the whole window; later rounds refill only the newest column.
   always_comb begin
      base      = (round == '0) ? '0 : BASE_COL;
      k_last    = ((round == '0) ? N_FULL : N_COL) - ADDR_W'(1);
      adrs_cur  = base + k;
      adrs_prev = adrs_cur - ADDR_W'(1);
      accept    = s_valid && s_ready;
      last_pix  = (k == k_last);
   end

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: next-state is defaulted before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = COLLECT;
         COLLECT: if (accept && last_pix) state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT:    if (pu_done) state_nxt = (round == LAST_ROUND) ? IDLE : COLLECT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready    = (state == COLLECT);
      start_nxt  = (state == START);
      round_done = (state == WAIT) && pu_done;
      frame_end  = round_done && (round == LAST_ROUND);
   end

   // start lands one cycle after the final registered write.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         start      <= 1'b0;
         frame_done <= 1'b0;
         round      <= '0;
      end else begin
         start      <= start_nxt;
         frame_done <= frame_end;
         if (round_done) round <= frame_end ? '0 : round + ROUND_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         k         <= '0;
         hold_full <= 1'b0;
         wr1       <= 1'b0;
         wr2       <= 1'b0;
         new1      <= '0;
         new2      <= '0;
         adrs_in1  <= '0;
         adrs_in2  <= '0;
      end else begin
         wr1 <= 1'b0;
         wr2 <= 1'b0;
         if (state != COLLECT) k <= '0;
         else if (accept)      k <= last_pix ? '0 : k + ADDR_W'(1);
         if (accept) begin
            if (hold_full) begin
               new1      <= hold_data;
               adrs_in1  <= adrs_prev;
               new2      <= s_data;
               adrs_in2  <= adrs_cur;
               wr1       <= 1'b1;
               wr2       <= 1'b1;
               hold_full <= 1'b0;
            end else if (last_pix) begin
               new1     <= s_data;
               adrs_in1 <= adrs_cur;
               wr1      <= 1'b1;
            end else begin
               hold_full <= 1'b1;
            end
         end
      end
   end

   // NOTE: the hold data register carries no reset; hold_full alone decides
   // whether its contents are meaningful.
   always_ff @(posedge clk) begin
      if (accept && !hold_full && !last_pix) hold_data <= s_data;
   end

`ifdef FEEDER_STALL_CNT_EN
   // Cleared on each frame's round-0 entry; saturates rather than wrapping.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stall_cnt <= '0;
      end else if (state == IDLE && state_nxt == COLLECT) begin
         stall_cnt <= '0;
      end else if (state == COLLECT && !s_valid && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/pu_feeder.md
Name: pu_feeder

Overview:
Streaming front-end that loads an img2col processing unit's dual-write window register file. Accepts one pixel per cycle on a valid/ready stream and pairs pixels into two simultaneous writes (port 1/port 2) at sequential window addresses. Pulses start and the round index to the PU once each round's pixels are written, then waits for the PU's round-complete pulse. It sits between the AXI read path and the PU.

Parameters:
DATA_WIDTH, 16, pixel width
KSIZE, 5, kernel edge; full window = KSIZE*KSIZE = 25 entries
ADDR_W, 5, window address width
ROUND_W, 6, width of round index
ROUNDS, 32, rounds per frame; legal range 1..2**ROUND_W

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
en  in  1  level; feeder leaves IDLE only while high
s_valid  in  1  input pixel valid
s_data  in  DATA_WIDTH  input pixel
s_ready  out  1  feeder accepts pixel this cycle
new1  out  DATA_WIDTH  write data, port 1
new2  out  DATA_WIDTH  write data, port 2
adrs_in1  out  ADDR_W  write address, port 1
adrs_in2  out  ADDR_W  write address, port 2
wr1  out  1  port 1 write strobe
wr2  out  1  port 2 write strobe
start  out  1  one-cycle pulse: round loaded
round  out  ROUND_W  current round index
pu_done  in  1  one-cycle pulse from PU: round consumed
frame_done  out  1  one-cycle pulse after last round's pu_done

Behaviour:
- Clock is clk. Reset is nrst: asynchronous, active-low. Every output resets to 0, state resets to IDLE, and the hold register is emptied.
- Round load size N: round 0 = KSIZE*KSIZE (25), addresses 0..24. Round r>0 = KSIZE (5), addresses KSIZE*(KSIZE-1)..KSIZE*KSIZE-1 (20..24). The PU shifts reserved columns internally.
- States:
  - IDLE: go to COLLECT when en=1.
  - COLLECT: s_ready=1. Stay until all N pixels are accepted, then go to START.
  - START: start=1 for exactly this cycle. Go to WAIT.
  - WAIT: s_ready=0. On pu_done:
    - If round==ROUNDS-1: round<=0, frame_done=1 next cycle, go to IDLE.
    - Else: round<=round+1, go to COLLECT.
- Accept rule: a pixel transfers when s_valid&&s_ready. Pixel counter k runs 0..N-1.
- Pairing:
  - Hold empty and k is not the last pixel: store in hold, no write.
  - Hold full: next cycle new1=hold, adrs_in1=base+k-1, new2=pixel, adrs_in2=base+k, wr1=wr2=1. Hold empties.
  - Hold empty and k==N-1 (odd N): next cycle wr1=1 only, new1=pixel, adrs_in1=base+k, wr2=0.
- Write outputs are registered, 1 cycle after accept. wr1/wr2 are 0 on every cycle with no write. Data and address hold their last value when strobes are 0.
- start asserts the cycle after the final write cycle. The final write is always complete before start.
- round is stable from COLLECT entry through WAIT. It updates on the cycle after pu_done.
- s_valid low in COLLECT: no progress, hold retained indefinitely.
- pu_done outside WAIT is ignored.
- en dropping mid-round has no effect. The frame completes; en is sampled only in IDLE.
- Address arithmetic is unsigned ADDR_W. base+k never exceeds 24.

Optional Feature:
FEEDER_STALL_CNT_EN:
- Defined: adds output stall_cnt [15:0]. It counts cycles in COLLECT with s_valid=0, saturates at 16'hFFFF, clears on reset and on each round-0 COLLECT entry.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-COLLECT after 7 pixels -> all outputs 0 immediately (async); next round 0 restarts at address 0.
- en=1, 25 back-to-back pixels 0x0001..0x0019 -> 12 paired writes ((0,1)…(22,23) with data (1,2)…) plus single wr1 addr 24 data 0x0019; start pulses 1 cycle later with round=0.
- pu_done after round 0, then 5 pixels 0xA0..0xA4 -> pairs (20,21),(22,23), single 24; start with round=1.
- s_valid toggling 1/0 during round 0 -> same address/data sequence as the back-to-back case; with FEEDER_STALL_CNT_EN, stall_cnt equals number of low-valid cycles.
- ROUNDS=2: complete 2 rounds, pu_done in round 1 -> frame_done single pulse, round=0, state IDLE, s_ready=0.
- pu_done pulsed during COLLECT -> ignored; round unchanged, start not repeated.
